// File: rtl/shared_mailbox_wb.sv
// Wishbone-attached 32-bit mailbox FIFO with sticky overflow/underflow flags
// and a count-threshold level interrupt.
module shared_mailbox_wb #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   output logic        mbox_irq_o
);

   typedef enum logic {S_IDLE, S_ACK} state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t state, state_next;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [AW:0]   count, count_n;
   logic          ovf, unf, ovf_n, unf_n;
   logic          irq_en, irq_en_n;
   logic [7:0]    thresh, thresh_n;
   logic [31:0]   dat_n;
   logic          irq_n;
   logic          push;
   logic          accept;
   logic          full, empty;
   logic [31:0]   wmask, count32, status_word;
   logic          unused_adr;

   assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

   assign accept = (state == S_IDLE) && wb_cyc_i && wb_stb_i;
   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign wb_ack_o = (state == S_ACK);

   assign wmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign count32 = 32'(count);
   assign status_word = {16'h0, count32[7:0], 4'h0, unf, ovf, full, empty};

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (wb_cyc_i && wb_stb_i) state_next = S_ACK;
         S_ACK:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      count_n  = count;
      ovf_n    = ovf;
      unf_n    = unf;
      irq_en_n = irq_en;
      thresh_n = thresh;
      dat_n    = wb_dat_o;
      push     = 1'b0;
      if (accept) begin
         case (wb_adr_i[3:2])
            2'd0: begin
               if (wb_we_i) begin
                  if (full) ovf_n = 1'b1;
                  else begin
                     push     = 1'b1;
                     wr_ptr_n = wr_ptr + 1'b1;
                     count_n  = count + 1'b1;
                  end
               end else begin
                  if (empty) begin
                     dat_n = '0;
                     unf_n = 1'b1;
                  end else begin
                     dat_n    = mem[rd_ptr];
                     rd_ptr_n = rd_ptr + 1'b1;
                     count_n  = count - 1'b1;
                  end
               end
            end
            2'd1: begin
               if (wb_we_i) begin
                  if (wb_sel_i[0] && wb_dat_i[2]) ovf_n = 1'b0;
                  if (wb_sel_i[0] && wb_dat_i[3]) unf_n = 1'b0;
               end else dat_n = status_word;
            end
            2'd2: begin
               if (wb_we_i) begin
                  if (wb_sel_i[0]) begin
                     irq_en_n = wb_dat_i[0];
                     // flush rewinds the FIFO only; memory and sticky flags survive
                     if (wb_dat_i[1]) begin
                        wr_ptr_n = '0;
                        rd_ptr_n = '0;
                        count_n  = '0;
                     end
                  end
               end else dat_n = {31'h0, irq_en};
            end
            default: begin
               if (wb_we_i) begin
                  if (wb_sel_i[0]) thresh_n = wb_dat_i[7:0];
               end else dat_n = {24'h0, thresh};
            end
         endcase
      end
      irq_n = irq_en_n && (thresh_n != '0) && (9'(count_n) >= {1'b0, thresh_n});
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ovf        <= 1'b0;
         unf        <= 1'b0;
         irq_en     <= 1'b0;
         thresh     <= '0;
         wb_dat_o   <= '0;
         mbox_irq_o <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_n;
         rd_ptr     <= rd_ptr_n;
         count      <= count_n;
         ovf        <= ovf_n;
         unf        <= unf_n;
         irq_en     <= irq_en_n;
         thresh     <= thresh_n;
         wb_dat_o   <= dat_n;
         mbox_irq_o <= irq_n;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push && !wb_rst_i) mem[wr_ptr] <= wb_dat_i & wmask;
   end

endmodule

// File: tb/tb_shared_mailbox_wb.sv
// Directed bench for shared_mailbox_wb (DEPTH=8): FIFO order, flags, IRQ,
// byte lanes, held strobe and reset during ACK.
module tb_shared_mailbox_wb;

   localparam logic [1:0] R_DATA = 2'd0, R_STAT = 2'd1, R_CTRL = 2'd2, R_THR = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] adr, dat_i, dat_o;
   logic [3:0]  sel;
   logic        we, cyc, stb, ack, irq;
   int          n_assert = 0;
   int          n_fail = 0;
   logic [31:0] rdata;
   int          lat;
   int          acks;

   always #5 clk = ~clk;

   shared_mailbox_wb #(.DEPTH(8)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
      .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
      .wb_ack_o(ack), .wb_dat_o(dat_o), .mbox_irq_o(irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One access; returns once the FSM is back in IDLE.
   task automatic bus(input logic [1:0] r, input logic w, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd, output int l);
      @(negedge clk);
      adr = {28'h0, r, 2'b00}; dat_i = wd; sel = ws; we = w; cyc = 1'b1; stb = 1'b1;
      l = 0;
      do begin
         @(posedge clk); #1; l++;
      end while (ack !== 1'b1 && l < 8);
      rd = dat_o;
      chk("ack_seen", {31'h0, ack}, 32'h1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [1:0] r, input logic [31:0] wd, input logic [3:0] ws);
      logic [31:0] d;
      int l;
      bus(r, 1'b1, wd, ws, d, l);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] r, input logic [31:0] exp);
      logic [31:0] d;
      int l;
      bus(r, 1'b0, 32'h0, 4'hF, d, l);
      chk(tag, d, exp);
   endtask

   initial begin
      rst = 1'b1; adr = '0; dat_i = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_dat", dat_o, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);

      // request presented in the first cycle with reset low
      @(negedge clk);
      rst = 1'b0; adr = 32'h4; we = 1'b0; cyc = 1'b1; stb = 1'b1; sel = 4'hF;
      @(posedge clk); #1;
      chk("first_req_ack", {31'h0, ack}, 32'h1);
      chk("first_req_status", dat_o, 32'h1);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;

      // fill / drain
      for (int i = 1; i <= 8; i++) wr(R_DATA, 32'(32'h11 * i), 4'hF);
      rd_chk("fill_status", R_STAT, 32'h0000_0802);
      for (int i = 1; i <= 8; i++) rd_chk($sformatf("drain%0d", i), R_DATA, 32'(32'h11 * i));
      rd_chk("drain_status", R_STAT, 32'h0000_0001);

      // overflow and pointer wrap
      for (int i = 1; i <= 9; i++) wr(R_DATA, 32'h100 + 32'(i), 4'hF);
      rd_chk("ovf_status", R_STAT, 32'h0000_0806);
      for (int i = 1; i <= 3; i++) rd_chk($sformatf("wrap_pop%0d", i), R_DATA, 32'h100 + 32'(i));
      for (int i = 1; i <= 3; i++) wr(R_DATA, 32'h200 + 32'(i), 4'hF);
      rd_chk("wrap_status", R_STAT, 32'h0000_0806);
      for (int i = 4; i <= 8; i++) rd_chk($sformatf("wrap_old%0d", i), R_DATA, 32'h100 + 32'(i));
      for (int i = 1; i <= 3; i++) rd_chk($sformatf("wrap_new%0d", i), R_DATA, 32'h200 + 32'(i));
      rd_chk("ovf_kept", R_STAT, 32'h0000_0005);
      wr(R_STAT, 32'h0000_0004, 4'hF);
      rd_chk("ovf_cleared", R_STAT, 32'h0000_0001);

      // underflow
      bus(R_DATA, 1'b0, 32'h0, 4'hF, rdata, lat);
      chk("unf_latency", 32'(lat), 32'd1);
      chk("unf_data", rdata, 32'h0);
      rd_chk("unf_status", R_STAT, 32'h0000_0009);
      wr(R_STAT, 32'hFFFF_FFF3, 4'hF);
      rd_chk("w1c_other_bits", R_STAT, 32'h0000_0009);
      wr(R_STAT, 32'h0000_0008, 4'hE);
      rd_chk("w1c_needs_lane0", R_STAT, 32'h0000_0009);
      wr(R_STAT, 32'h0000_0008, 4'h1);
      rd_chk("unf_cleared", R_STAT, 32'h0000_0001);

      // interrupt threshold
      wr(R_THR, 32'h3, 4'hF);
      wr(R_CTRL, 32'h1, 4'hF);
      rd_chk("thresh_rd", R_THR, 32'h3);
      rd_chk("ctrl_rd", R_CTRL, 32'h1);
      wr(R_DATA, 32'hA1, 4'hF);
      wr(R_DATA, 32'hA2, 4'hF);
      chk("irq_below", {31'h0, irq}, 32'h0);
      wr(R_DATA, 32'hA3, 4'hF);
      chk("irq_at_thresh", {31'h0, irq}, 32'h1);
      rd_chk("irq_pop", R_DATA, 32'hA1);
      chk("irq_after_pop", {31'h0, irq}, 32'h0);
      rd_chk("irq_pop2", R_DATA, 32'hA2);
      rd_chk("irq_pop3", R_DATA, 32'hA3);

      // threshold beyond depth, flush, zero threshold
      wr(R_THR, 32'h9, 4'hF);
      for (int i = 1; i <= 8; i++) wr(R_DATA, 32'hC0 + 32'(i), 4'hF);
      chk("irq_thresh_gt_depth", {31'h0, irq}, 32'h0);
      wr(R_CTRL, 32'h3, 4'hF);
      rd_chk("flush_status", R_STAT, 32'h0000_0001);
      rd_chk("flush_ctrl", R_CTRL, 32'h1);
      wr(R_THR, 32'h0, 4'hF);
      wr(R_DATA, 32'hD1, 4'hF);
      chk("irq_thresh_zero", {31'h0, irq}, 32'h0);
      wr(R_CTRL, 32'h2, 4'hF);
      rd_chk("flush2_ctrl", R_CTRL, 32'h0);
      rd_chk("flush2_status", R_STAT, 32'h0000_0001);

      // byte lanes
      wr(R_DATA, 32'hAABB_CCDD, 4'b0101);
      rd_chk("lane_pop", R_DATA, 32'h00BB_00DD);
      wr(R_THR, 32'h5, 4'hF);
      wr(R_THR, 32'h7, 4'hE);
      rd_chk("thresh_no_lane0", R_THR, 32'h5);

      // strobe held for 6 cycles: accepted on edges 1, 3, 5
      @(negedge clk);
      adr = 32'h0; we = 1'b1; cyc = 1'b1; stb = 1'b1; sel = 4'hF; acks = 0;
      for (int k = 0; k < 6; k++) begin
         dat_i = 32'h70 + 32'(k);
         @(posedge clk); #1;
         if (ack === 1'b1) acks++;
         if (k < 5) @(negedge clk);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      chk("held_acks", 32'(acks), 32'd3);
      rd_chk("held_status", R_STAT, 32'h0000_0300);
      rd_chk("held_pop1", R_DATA, 32'h70);
      rd_chk("held_pop2", R_DATA, 32'h72);
      rd_chk("held_pop3", R_DATA, 32'h74);

      // reset during ACK
      wr(R_THR, 32'h2, 4'hF);
      wr(R_CTRL, 32'h1, 4'hF);
      wr(R_DATA, 32'h55, 4'hF);
      @(negedge clk);
      adr = 32'h0; we = 1'b1; cyc = 1'b1; stb = 1'b1; dat_i = 32'h99; sel = 4'hF;
      @(posedge clk); #1;
      chk("ack_before_rst", {31'h0, ack}, 32'h1);
      chk("irq_before_rst", {31'h0, irq}, 32'h1);
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ack_ack", {31'h0, ack}, 32'h0);
      chk("rst_in_ack_dat", dat_o, 32'h0);
      chk("rst_in_ack_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      rst = 1'b0; adr = 32'h4; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ack", {31'h0, ack}, 32'h1);
      chk("post_rst_status", dat_o, 32'h1);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      rd_chk("post_rst_thresh", R_THR, 32'h0);
      rd_chk("post_rst_ctrl", R_CTRL, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
